// File: rtl/bist_resp_checker_pkg.sv
// Shared state encoding and latency limits for the BIST response checker.
package bist_resp_checker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } bist_state_e;

  localparam int MAX_READ_LATENCY = 4;
  localparam int DRAIN_CNT_W      = $clog2(MAX_READ_LATENCY + 1);

endpackage

// File: rtl/bist_resp_checker_rd_pipe.sv
// Fixed-depth valid+payload shift pipe; DEPTH cycles push-to-tail, shifts every cycle, no backpressure.
// Flush drops all in-flight entries on the next edge.
module bist_resp_checker_rd_pipe #(
  parameter int W     = 40,
  parameter int DEPTH = 1
) (
  input  logic         i_clk,
  input  logic         i_rstb,
  input  logic         i_flush,
  input  logic         i_push_vld,
  input  logic [W-1:0] i_push_dat,
  output logic         o_tail_vld,
  output logic [W-1:0] o_tail_dat
);

  logic [DEPTH-1:0] r_vld;
  logic [W-1:0]     r_dat [DEPTH];

  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      r_vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_dat[i] <= '0;
      end
    end else begin
      r_vld[0] <= i_push_vld && !i_flush;
      r_dat[0] <= i_push_dat;
      for (int i = 1; i < DEPTH; i++) begin
        r_vld[i] <= r_vld[i-1] && !i_flush;
        r_dat[i] <= r_dat[i-1];
      end
    end
  end

  assign o_tail_vld = r_vld[DEPTH-1];
  assign o_tail_dat = r_dat[DEPTH-1];

endmodule

// File: rtl/bist_resp_checker.sv
// Drives the SRAM from pattern-generator ops and checks read data READ_LATENCY cycles later.
// Combinational SRAM drive; generator is stalled via o_pg_en (en low or not RUN), never by the SRAM.
module bist_resp_checker
  import bist_resp_checker_pkg::*;
#(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int MASK_WIDTH   = 4,
  parameter int READ_LATENCY = 1,
  parameter int ERR_WIDTH    = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rstb,
  input  logic                  i_en,
  input  logic                  i_clear,
  output logic                  o_pg_en,
  input  logic [ADDR_WIDTH-1:0] i_pg_addr,
  input  logic [DATA_WIDTH-1:0] i_pg_data,
  input  logic [DATA_WIDTH-1:0] i_pg_check,
  input  logic [MASK_WIDTH-1:0] i_pg_wmask,
  input  logic                  i_pg_we,
  input  logic                  i_pg_re,
  input  logic                  i_pg_done,
  output logic                  o_sram_ce,
  output logic                  o_sram_we,
  output logic [ADDR_WIDTH-1:0] o_sram_addr,
  output logic [DATA_WIDTH-1:0] o_sram_din,
  output logic [MASK_WIDTH-1:0] o_sram_wmask,
  input  logic [DATA_WIDTH-1:0] i_sram_dout,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_fail,
  output logic                  o_proto_err,
  output logic [ERR_WIDTH-1:0]  o_err_cnt,
  output logic [ADDR_WIDTH-1:0] o_ff_addr,
  output logic [DATA_WIDTH-1:0] o_ff_exp,
  output logic [DATA_WIDTH-1:0] o_ff_got
);

  localparam int PW = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [DRAIN_CNT_W-1:0] LAT_LAST = DRAIN_CNT_W'(READ_LATENCY - 1);

  bist_state_e            r_state, w_state_nxt;
  logic [DRAIN_CNT_W-1:0] r_drain_cnt, w_drain_cnt_nxt;

  logic                  w_issue;
  logic                  w_rd_push;
  logic                  w_tail_vld;
  logic [PW-1:0]         w_tail_dat;
  logic [ADDR_WIDTH-1:0] w_tail_addr;
  logic [DATA_WIDTH-1:0] w_tail_check;
  logic                  w_mismatch;

  logic                  r_fail;
  logic                  r_proto_err;
  logic [ERR_WIDTH-1:0]  r_err_cnt;
  logic [ADDR_WIDTH-1:0] r_ff_addr;
  logic [DATA_WIDTH-1:0] r_ff_exp;
  logic [DATA_WIDTH-1:0] r_ff_got;

  assign w_issue   = (r_state == RUN) && i_en;
  // A simultaneous re&&we is executed as a write only, so it never schedules a compare.
  assign w_rd_push = w_issue && i_pg_re && !i_pg_we;

  assign o_pg_en      = w_issue;
  assign o_sram_ce    = w_issue && (i_pg_re || i_pg_we);
  assign o_sram_we    = w_issue && i_pg_we;
  assign o_sram_addr  = i_pg_addr;
  assign o_sram_din   = i_pg_data;
  assign o_sram_wmask = i_pg_wmask;

  bist_resp_checker_rd_pipe #(
    .W     (PW),
    .DEPTH (READ_LATENCY)
  ) u_rd_pipe (
    .i_clk      (i_clk),
    .i_rstb     (i_rstb),
    .i_flush    (i_clear),
    .i_push_vld (w_rd_push),
    .i_push_dat ({i_pg_addr, i_pg_check}),
    .o_tail_vld (w_tail_vld),
    .o_tail_dat (w_tail_dat)
  );

  assign w_tail_addr  = w_tail_dat[PW-1 -: ADDR_WIDTH];
  assign w_tail_check = w_tail_dat[DATA_WIDTH-1:0];
  assign w_mismatch   = w_tail_vld && (i_sram_dout != w_tail_check);

  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      r_state     <= IDLE;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_drain_cnt_nxt = r_drain_cnt;
    if (i_clear) begin
      w_state_nxt     = IDLE;
      w_drain_cnt_nxt = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_en) w_state_nxt = RUN;
        end
        RUN: begin
          if (i_pg_done) begin
            w_state_nxt     = DRAIN;
            w_drain_cnt_nxt = '0;
          end
        end
        DRAIN: begin
          // Last in-flight read reaches the pipe tail during the final drain cycle.
          if (r_drain_cnt == LAT_LAST) begin
            w_state_nxt = DONE;
          end else begin
            w_drain_cnt_nxt = r_drain_cnt + DRAIN_CNT_W'(1);
          end
        end
        DONE: begin
          w_state_nxt = DONE;
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      r_fail      <= 1'b0;
      r_proto_err <= 1'b0;
      r_err_cnt   <= '0;
      r_ff_addr   <= '0;
      r_ff_exp    <= '0;
      r_ff_got    <= '0;
    end else if (i_clear) begin
      r_fail      <= 1'b0;
      r_proto_err <= 1'b0;
      r_err_cnt   <= '0;
      r_ff_addr   <= '0;
      r_ff_exp    <= '0;
      r_ff_got    <= '0;
    end else begin
      if (w_issue && i_pg_re && i_pg_we) begin
        r_proto_err <= 1'b1;
      end
      if (w_mismatch) begin
        r_fail <= 1'b1;
        if (r_err_cnt != '1) begin
          r_err_cnt <= r_err_cnt + ERR_WIDTH'(1);
        end
        if (r_err_cnt == '0) begin
          r_ff_addr <= w_tail_addr;
          r_ff_exp  <= w_tail_check;
          r_ff_got  <= i_sram_dout;
        end
      end
    end
  end

  assign o_busy      = (r_state == RUN) || (r_state == DRAIN);
  assign o_done      = (r_state == DONE);
  assign o_fail      = r_fail;
  assign o_proto_err = r_proto_err;
  assign o_err_cnt   = r_err_cnt;
  assign o_ff_addr   = r_ff_addr;
  assign o_ff_exp    = r_ff_exp;
  assign o_ff_got    = r_ff_got;

  a_lat_range: assert property (@(posedge i_clk)
    (READ_LATENCY >= 1) && (READ_LATENCY <= MAX_READ_LATENCY) && ((DATA_WIDTH % MASK_WIDTH) == 0));

  a_we_needs_ce: assert property (@(posedge i_clk) disable iff (!i_rstb)
    !(!o_sram_ce && o_sram_we));

  a_err_monotonic: assert property (@(posedge i_clk) disable iff (!i_rstb)
    !$past(i_clear) |-> (o_err_cnt >= $past(o_err_cnt)));

endmodule

// File: tb/tb_bist_resp_checker.sv
// Directed bench: LAT=1/ERR_WIDTH=16 and LAT=3/ERR_WIDTH=2 checkers share one stimulus stream,
// each fed by its own behavioural SRAM read-latency model with per-address bit-flip injection.
module tb_bist_resp_checker;

  logic        clk = 1'b0;
  logic        rstb;
  logic        en, clear;
  logic [7:0]  pg_addr;
  logic [31:0] pg_data, pg_check;
  logic [3:0]  pg_wmask;
  logic        pg_we, pg_re, pg_done;

  logic        pg_en_a, ce_a, we_a, busy_a, done_a, fail_a, proto_a;
  logic [7:0]  addr_a, ff_addr_a;
  logic [31:0] din_a, dout_a, ff_exp_a, ff_got_a;
  logic [3:0]  wmask_a;
  logic [15:0] err_a;

  logic        pg_en_b, ce_b, we_b, busy_b, done_b, fail_b, proto_b;
  logic [7:0]  addr_b, ff_addr_b;
  logic [31:0] din_b, ff_exp_b, ff_got_b;
  logic [3:0]  wmask_b;
  logic [1:0]  err_b;

  logic [31:0] mem  [256];
  logic [31:0] flip [256];
  logic [31:0] rd_b [3];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bist_resp_checker #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .MASK_WIDTH(4), .READ_LATENCY(1), .ERR_WIDTH(16)) u_a (
    .i_clk(clk), .i_rstb(rstb), .i_en(en), .i_clear(clear), .o_pg_en(pg_en_a),
    .i_pg_addr(pg_addr), .i_pg_data(pg_data), .i_pg_check(pg_check), .i_pg_wmask(pg_wmask),
    .i_pg_we(pg_we), .i_pg_re(pg_re), .i_pg_done(pg_done),
    .o_sram_ce(ce_a), .o_sram_we(we_a), .o_sram_addr(addr_a), .o_sram_din(din_a),
    .o_sram_wmask(wmask_a), .i_sram_dout(dout_a),
    .o_busy(busy_a), .o_done(done_a), .o_fail(fail_a), .o_proto_err(proto_a), .o_err_cnt(err_a),
    .o_ff_addr(ff_addr_a), .o_ff_exp(ff_exp_a), .o_ff_got(ff_got_a)
  );

  bist_resp_checker #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .MASK_WIDTH(4), .READ_LATENCY(3), .ERR_WIDTH(2)) u_b (
    .i_clk(clk), .i_rstb(rstb), .i_en(en), .i_clear(clear), .o_pg_en(pg_en_b),
    .i_pg_addr(pg_addr), .i_pg_data(pg_data), .i_pg_check(pg_check), .i_pg_wmask(pg_wmask),
    .i_pg_we(pg_we), .i_pg_re(pg_re), .i_pg_done(pg_done),
    .o_sram_ce(ce_b), .o_sram_we(we_b), .o_sram_addr(addr_b), .o_sram_din(din_b),
    .o_sram_wmask(wmask_b), .i_sram_dout(rd_b[2]),
    .o_busy(busy_b), .o_done(done_b), .o_fail(fail_b), .o_proto_err(proto_b), .o_err_cnt(err_b),
    .o_ff_addr(ff_addr_b), .o_ff_exp(ff_exp_b), .o_ff_got(ff_got_b)
  );

  // Both checkers see identical ops while RUN, so writes are taken from instance A only.
  always @(posedge clk) begin
    if (ce_a && we_a) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask_a[b]) mem[addr_a][8*b +: 8] <= din_a[8*b +: 8];
      end
    end
    if (ce_a && !we_a) dout_a <= mem[addr_a] ^ flip[addr_a];
    if (ce_b && !we_b) rd_b[0] <= mem[addr_b] ^ flip[addr_b];
    rd_b[1] <= rd_b[0];
    rd_b[2] <= rd_b[1];
  end

  function automatic logic [31:0] pat(input logic [7:0] a);
    return {a, ~a, a ^ 8'h5A, 8'h3C};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_chk++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic re, input logic we, input logic [7:0] a,
                        input logic [31:0] d, input logic [31:0] c, input logic dn);
    pg_re    = re;
    pg_we    = we;
    pg_addr  = a;
    pg_data  = d;
    pg_check = c;
    pg_wmask = 4'hF;
    pg_done  = dn;
  endtask

  task automatic set_idle();
    set_op(1'b0, 1'b0, 8'h00, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic run_start();
    set_idle();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
  endtask

  task automatic read_pass();
    for (int a = 0; a < 256; a++) begin
      set_op(1'b1, 1'b0, 8'(a), 32'h0, pat(8'(a)), a == 255);
      tick();
    end
    set_idle();
    tick(); tick(); tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]  = 32'h0;
      flip[i] = 32'h0;
    end
    rd_b[0] = 32'h0; rd_b[1] = 32'h0; rd_b[2] = 32'h0;
    dout_a  = 32'h0;
    rstb  = 1'b0;
    en    = 1'b0;
    clear = 1'b0;
    set_idle();
    tick(); tick();

    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_fail", fail_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_ff_addr", ff_addr_a, 0);
    chk("rst_pg_en", pg_en_a, 0);

    // March: write all, then read all with done on the last read
    rstb = 1'b1;
    tick();
    en = 1'b1;
    tick();
    chk("run_busy", busy_a, 1);
    chk("run_pg_en", pg_en_a, 1);
    for (int a = 0; a < 256; a++) begin
      set_op(1'b0, 1'b1, 8'(a), pat(8'(a)), 32'h0, 1'b0);
      if (a == 8'h33) begin
        #1;
        chk("wr_ce", ce_a, 1);
        chk("wr_we", we_a, 1);
        chk("wr_addr", addr_a, 8'h33);
        chk("wr_din", din_a, pat(8'h33));
      end
      tick();
    end
    for (int a = 0; a < 256; a++) begin
      set_op(1'b1, 1'b0, 8'(a), 32'h0, pat(8'(a)), a == 255);
      tick();
    end
    set_idle();
    chk("t1_drain_done", done_a, 0);
    chk("t1_drain_busy", busy_a, 1);
    tick();
    chk("t1_done_a", done_a, 1);
    chk("t1_busy_a", busy_a, 0);
    chk("t1_fail_a", fail_a, 0);
    chk("t1_err_a", err_a, 0);
    tick();
    chk("t1_b_not_done", done_b, 0);
    tick();
    chk("t1_done_b", done_b, 1);
    chk("t1_err_b", err_b, 0);

    // Single bit flip at 0x17 bit 3
    flip[8'h17] = 32'h8;
    run_start();
    read_pass();
    chk("t2_done", done_a, 1);
    chk("t2_fail", fail_a, 1);
    chk("t2_err", err_a, 1);
    chk("t2_ff_addr", ff_addr_a, 8'h17);
    chk("t2_ff_exp", ff_exp_a, pat(8'h17));
    chk("t2_ff_got", ff_got_a, pat(8'h17) ^ 32'h8);
    chk("t2_err_b", err_b, 1);
    chk("t2_ff_addr_b", ff_addr_b, 8'h17);

    // Two flips: first-fail capture kept; then five flips saturate the 2-bit counter
    flip[8'h17] = 32'h0;
    flip[8'h05] = 32'h1;
    flip[8'h40] = 32'h8000_0000;
    run_start();
    read_pass();
    chk("t3_err2", err_a, 2);
    chk("t3_ff_addr", ff_addr_a, 8'h05);
    chk("t3_ff_got", ff_got_a, pat(8'h05) ^ 32'h1);
    chk("t3_err2_b", err_b, 2);
    flip[8'h80] = 32'h10;
    flip[8'h81] = 32'h100;
    flip[8'hFF] = 32'h1000;
    run_start();
    read_pass();
    chk("t3_err5", err_a, 5);
    chk("t3_sat_b", err_b, 3);
    chk("t3_ff_addr_b", ff_addr_b, 8'h05);

    // Clear from DONE: status holds until the edge, then everything returns to IDLE/zero
    clear = 1'b1;
    #1;
    chk("clr_pre_done", done_a, 1);
    tick();
    chk("clr_done", done_a, 0);
    chk("clr_busy", busy_a, 0);
    chk("clr_fail", fail_a, 0);
    chk("clr_err", err_a, 0);
    chk("clr_ff_addr", ff_addr_a, 0);
    chk("clr_ff_got", ff_got_a, 0);
    clear = 1'b0;

    // LAT=3 back-to-back reads with a three-cycle en gap before addr 8
    for (int i = 0; i < 256; i++) flip[i] = 32'h0;
    flip[8'h08] = 32'h100;
    run_start();
    for (int a = 0; a < 16; a++) begin
      set_op(1'b1, 1'b0, 8'(a), 32'h0, pat(8'(a)), a == 15);
      if (a == 8) begin
        en = 1'b0;
        #1;
        chk("t4_pg_en_low", pg_en_b, 0);
        chk("t4_ce_low", ce_b, 0);
        tick(); tick(); tick();
        chk("t4_busy_gap", busy_b, 1);
        en = 1'b1;
      end
      tick();
    end
    set_idle();
    tick(); tick();
    chk("t4_not_done", done_b, 0);
    tick();
    chk("t4_done_b", done_b, 1);
    chk("t4_err_b", err_b, 1);
    chk("t4_ff_addr_b", ff_addr_b, 8'h08);
    chk("t4_ff_got_b", ff_got_b, pat(8'h08) ^ 32'h100);
    chk("t4_err_a", err_a, 1);

    // re&&we at 0x10: write wins, no compare, proto_err sticky
    run_start();
    set_op(1'b1, 1'b1, 8'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
    #1;
    chk("t5_ce", ce_a, 1);
    chk("t5_we", we_a, 1);
    tick();
    chk("t5_proto", proto_a, 1);
    set_op(1'b1, 1'b0, 8'h10, 32'h0, 32'hDEAD_BEEF, 1'b1);
    tick();
    set_idle();
    tick(); tick(); tick();
    chk("t5_err_a", err_a, 0);
    chk("t5_fail_a", fail_a, 0);
    chk("t5_err_b", err_b, 0);
    chk("t5_proto_b", proto_b, 1);
    chk("t5_done", done_a, 1);

    // Async reset in the middle of DRAIN
    flip[8'h01] = 32'h4;
    run_start();
    for (int a = 0; a < 3; a++) begin
      set_op(1'b1, 1'b0, 8'(a), 32'h0, pat(8'(a)), a == 2);
      tick();
    end
    set_idle();
    chk("t6_pre_err", err_a, 1);
    chk("t6_pre_busy", busy_b, 1);
    rstb = 1'b0;
    #1;
    chk("t6_busy_a", busy_a, 0);
    chk("t6_busy_b", busy_b, 0);
    chk("t6_err_a", err_a, 0);
    chk("t6_fail_a", fail_a, 0);
    chk("t6_ff_addr", ff_addr_a, 0);
    chk("t6_pg_en", pg_en_a, 0);
    tick(); tick();
    rstb = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
